// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: strobes the IR load, waits for it, checks the condition field
// and issues passing instructions to decode, then strobes the PC advance.
// Optional macro FETCH_PERF_CNT_EN adds issued/skipped instruction counters.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        halt_req_i,
    input  logic        clear_fault_i,
    input  logic        w_ir_valid_i,
    input  logic [31:0] ir_i,
    input  logic [3:0]  nzcv_i,
    input  logic        dec_ready_i,
    output logic        write_ir_o,
    output logic        write_pc_o,
    output logic [31:0] ir_out_o,
    output logic        ir_out_valid_o,
    output logic        busy_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] issued_cnt_o,
    output logic [31:0] skipped_cnt_o,
`endif
    output logic        fault_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StPcUpd,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            halt_pend_q, halt_pend_d;
    logic [31:0]     ir_out_q, ir_out_d;
    logic            cond_pass;

    logic flag_n, flag_z, flag_c, flag_v;
    assign flag_n = nzcv_i[3];
    assign flag_z = nzcv_i[2];
    assign flag_c = nzcv_i[1];
    assign flag_v = nzcv_i[0];

    always_comb begin
        cond_pass = 1'b0;
        unique case (ir_i[31:28])
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            4'hF: cond_pass = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            ir_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            ir_out_q    <= ir_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StFetch;
            StFetch: state_d = StWait;
            StWait: begin
                // A valid on the last permitted WAIT cycle still wins over the timeout.
                if (w_ir_valid_i) state_d = cond_pass ? StIssue : StPcUpd;
                else if (cnt_q == CntLast) state_d = StFault;
            end
            StIssue: if (dec_ready_i) state_d = StPcUpd;
            StPcUpd: state_d = (halt_pend_q || halt_req_i) ? StIdle : StFetch;
            StFault: if (clear_fault_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        ir_out_d    = ir_out_q;
        unique case (state_q)
            StIdle:  if (start_i) halt_pend_d = 1'b0;
            StFault: if (clear_fault_i) halt_pend_d = 1'b0;
            default: if (halt_req_i) halt_pend_d = 1'b1;
        endcase
        if (state_q == StFetch) cnt_d = '0;
        else if (state_q == StWait && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (state_q == StWait && w_ir_valid_i) ir_out_d = ir_i;
    end

    always_comb begin
        write_ir_o     = 1'b0;
        write_pc_o     = 1'b0;
        ir_out_valid_o = 1'b0;
        busy_o         = 1'b1;
        fault_o        = 1'b0;
        unique case (state_q)
            StIdle:  busy_o = 1'b0;
            StFetch: write_ir_o = 1'b1;
            StWait:  ;
            StIssue: ir_out_valid_o = 1'b1;
            StPcUpd: write_pc_o = 1'b1;
            StFault: begin
                busy_o  = 1'b0;
                fault_o = 1'b1;
            end
            default: busy_o = 1'b0;
        endcase
    end

    assign ir_out_o = ir_out_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issued_q, skipped_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_q  <= '0;
            skipped_q <= '0;
        end else begin
            if (state_q == StIssue && dec_ready_i) issued_q <= issued_q + 32'd1;
            if (state_q == StWait && w_ir_valid_i && !cond_pass) skipped_q <= skipped_q + 32'd1;
        end
    end

    assign issued_cnt_o  = issued_q;
    assign skipped_cnt_o = skipped_q;
`endif

endmodule
